// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: PC width, reset value,
// FSM state encoding, redirect-source encoding and a PC alignment helper.
package pc_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Sequencer state: BOOT for one cycle after reset, RUN while fetching,
  // TRAP after a misaligned target load (only reachable with the trap build).
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  // Which calculator won the redirect priority this cycle (debug only).
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_J    = 2'd2,
    SRC_JR   = 2'd3
  } pc_src_e;

  // Clear the two byte-offset bits so a loaded target is word aligned.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its environment (target calculators,
// hazard unit, instruction memory, IF/ID flush).
//
// Fetch handshake: a request is offered when FetchValid=1 and is taken on a
// rising edge where FetchValid=1, FetchReady=1 and Stall=0. While offered and
// not yet taken, FetchPC does not change; redirects arriving meanwhile are
// queued internally and never alter the outstanding request.
//
// Modport master is the sequencer (it originates fetch requests); modport
// slave is the surrounding pipeline and instruction memory.
interface pc_sequencer_if;
  import pc_pkg::*;

  logic            Stall;
  logic            Jump;
  logic [PC_W-1:0] JumpAddress;
  logic            Branch;
  logic [PC_W-1:0] BranchTarget;
  logic            JumpReg;
  logic [PC_W-1:0] RegTarget;
  logic            FetchReady;
  logic            FetchValid;
  logic [PC_W-1:0] FetchPC;
  logic [PC_W-1:0] PCPlus4;
  logic            Redirected;
  logic            Misaligned;
  pc_state_e       dbg_state;
  pc_src_e         dbg_src;

  modport master (
    input  Stall, Jump, JumpAddress, Branch, BranchTarget,
           JumpReg, RegTarget, FetchReady,
    output FetchValid, FetchPC, PCPlus4, Redirected, Misaligned,
           dbg_state, dbg_src
  );

  modport slave (
    output Stall, Jump, JumpAddress, Branch, BranchTarget,
           JumpReg, RegTarget, FetchReady,
    input  FetchValid, FetchPC, PCPlus4, Redirected, Misaligned,
           dbg_state, dbg_src
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational redirect arbiter: JumpReg beats Jump beats Branch.
module pc_redirect_sel
  import pc_pkg::*;
(
  input  logic            i_jump_reg,
  input  logic [PC_W-1:0] i_reg_tgt,
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_jump_addr,
  input  logic            i_branch,
  input  logic [PC_W-1:0] i_branch_tgt,
  output logic            o_req,
  output logic [PC_W-1:0] o_tgt,
  output pc_src_e         o_src
);

  // Pick the highest-priority active request and its target.
  always_comb begin
    o_req = 1'b0;
    o_tgt = '0;
    o_src = SRC_NONE;
    if (i_jump_reg) begin
      o_req = 1'b1;
      o_tgt = i_reg_tgt;
      o_src = SRC_JR;
    end else if (i_jump) begin
      o_req = 1'b1;
      o_tgt = i_jump_addr;
      o_src = SRC_J;
    end else if (i_branch) begin
      o_req = 1'b1;
      o_tgt = i_branch_tgt;
      o_src = SRC_BR;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, offers it to instruction memory over a
// valid/ready handshake, parks redirects that arrive while the request is not
// being taken, and pulses Redirected to flush IF/ID after a redirect load.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned target still loads
// but sends the sequencer to TRAP (sticky Misaligned, fetch stopped until
// reset). Without it, target bits [1:0] are cleared on load.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  pc_sequencer_if.master        bus
);

  pc_state_e       r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_valid;
  logic            r_redirected;
  logic            r_pend_valid;
  logic [PC_W-1:0] r_pend_tgt;

  logic            w_req;
  logic [PC_W-1:0] w_sel_tgt;
  pc_src_e         w_src;
  logic            w_acc;
  logic            w_redir;
  logic [PC_W-1:0] w_load_tgt;

  pc_redirect_sel u_sel (
    .i_jump_reg   (bus.JumpReg),
    .i_reg_tgt    (bus.RegTarget),
    .i_jump       (bus.Jump),
    .i_jump_addr  (bus.JumpAddress),
    .i_branch     (bus.Branch),
    .i_branch_tgt (bus.BranchTarget),
    .o_req        (w_req),
    .o_tgt        (w_sel_tgt),
    .o_src        (w_src)
  );

  // Stall overrides FetchReady; a live request beats a parked one.
  assign w_acc      = r_fetch_valid & bus.FetchReady & ~bus.Stall;
  assign w_redir    = w_req | r_pend_valid;
  assign w_load_tgt = w_req ? w_sel_tgt : r_pend_tgt;

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misaligned;
`endif

  // PC, pending redirect and FSM advance together; outputs are registered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_redirected  <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_tgt    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      r_misaligned  <= 1'b0;
`endif
    end else begin
      case (r_state)
        BOOT: begin
          r_state       <= RUN;
          r_fetch_valid <= 1'b1;
          r_redirected  <= 1'b0;
        end
        RUN: begin
          if (w_acc) begin
            r_pend_valid <= 1'b0;
            if (w_redir) begin
`ifdef PC_MISALIGN_TRAP_EN
              r_pc <= w_load_tgt;
              if (w_load_tgt[1:0] != 2'b00) begin
                r_state       <= TRAP;
                r_fetch_valid <= 1'b0;
                r_redirected  <= 1'b0;
                r_misaligned  <= 1'b1;
              end else begin
                r_redirected <= 1'b1;
              end
`else
              r_pc         <= align_pc(w_load_tgt);
              r_redirected <= 1'b1;
`endif
            end else begin
              r_pc         <= r_pc + PC_W'(4);
              r_redirected <= 1'b0;
            end
          end else begin
            // Request still outstanding: keep FetchPC, park the newest redirect.
            r_redirected <= 1'b0;
            if (w_req) begin
              r_pend_valid <= 1'b1;
              r_pend_tgt   <= w_sel_tgt;
            end
          end
        end
        TRAP: begin
          r_fetch_valid <= 1'b0;
          r_redirected  <= 1'b0;
        end
        default: begin
          r_state       <= BOOT;
          r_fetch_valid <= 1'b0;
          r_redirected  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.FetchValid = r_fetch_valid;
  assign bus.FetchPC    = r_pc;
  assign bus.PCPlus4    = r_pc + PC_W'(4);
  assign bus.Redirected = r_redirected;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_src    = w_src;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.Misaligned = r_misaligned;
`else
  assign bus.Misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations,
// then randomized traffic with occasional mid-run resets, all compared each
// cycle against a queue-based behavioural model of the PC stage.
module tb_pc_sequencer;
  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The PC is a value that either steps by 4 or jumps; redirects not taken
  // yet wait in a queue of which only the newest entry matters.
  logic [31:0] m_pc;
  bit          m_valid, m_boot, m_trap, m_redir, m_mis;
  logic [31:0] pend_q[$];
  bit          mreq, macc;
  logic [31:0] mtgt, mload;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 0; m_boot = 1; m_trap = 0;
      m_redir = 0; m_mis = 0; pend_q.delete();
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1; m_redir = 0;
    end else if (!m_trap) begin
      mreq = bus.JumpReg || bus.Jump || bus.Branch;
      mtgt = bus.JumpReg ? bus.RegTarget :
             bus.Jump    ? bus.JumpAddress : bus.BranchTarget;
      macc = m_valid && bus.FetchReady && !bus.Stall;
      if (!macc) begin
        m_redir = 0;
        if (mreq) pend_q.push_back(mtgt);
      end else if (mreq || pend_q.size() > 0) begin
        mload = mreq ? mtgt : pend_q[$];
        pend_q.delete();
`ifdef PC_MISALIGN_TRAP_EN
        m_pc = mload;
        if (mload % 4 != 0) begin
          m_trap = 1; m_valid = 0; m_redir = 0; m_mis = 1;
        end else m_redir = 1;
`else
        m_pc = mload - (mload % 4);
        m_redir = 1;
`endif
      end else begin
        m_pc = m_pc + 32'd4;
        m_redir = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", 32'(bus.FetchValid), 32'(m_valid));
      chk("model_pc",    bus.FetchPC,         m_pc);
      chk("model_plus4", bus.PCPlus4,         m_pc + 32'd4);
      chk("model_redir", 32'(bus.Redirected), 32'(m_redir));
      chk("model_mis",   32'(bus.Misaligned), 32'(m_mis));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Stall = 0; bus.Jump = 0; bus.Branch = 0; bus.JumpReg = 0;
    bus.JumpAddress = '0; bus.BranchTarget = '0; bus.RegTarget = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask

  // Redirect to a given PC through JumpReg with an accept, one cycle.
  task automatic goto_pc(input logic [31:0] pc);
    bus.FetchReady = 1; bus.JumpReg = 1; bus.RegTarget = pc;
    step();
    bus.JumpReg = 0;
    chk("goto_pc", bus.FetchPC, pc);
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    idle_inputs();
    bus.FetchReady = 1;
    step(); step();
    chk_en = 1;
    step();
    chk("reset_valid", 32'(bus.FetchValid), 32'd0);
    chk("reset_pc",    bus.FetchPC,         32'h0);
    chk("reset_redir", 32'(bus.Redirected), 32'd0);
    rst_n = 1;

    // Boot cycle, then sequential fetch.
    chk("boot_valid", 32'(bus.FetchValid), 32'd0);
    step(); chk("seq_valid", 32'(bus.FetchValid), 32'd1);
    chk("seq_pc0", bus.FetchPC, 32'h0);
    step(); chk("seq_pc4", bus.FetchPC, 32'h4);
    step(); chk("seq_pc8", bus.FetchPC, 32'h8);
    step(); chk("seq_pcC", bus.FetchPC, 32'hC);
    step(); chk("seq_pc10", bus.FetchPC, 32'h10);

    // Jump with accept.
    bus.Jump = 1; bus.JumpAddress = 32'h0040_0100;
    step(); bus.Jump = 0;
    chk("jump_pc",    bus.FetchPC, 32'h0040_0100);
    chk("jump_redir", 32'(bus.Redirected), 32'd1);
    step();
    chk("jump_redir_off", 32'(bus.Redirected), 32'd0);
    chk("jump_pc_next",   bus.FetchPC, 32'h0040_0104);

    // Branch captured while not ready.
    goto_pc(32'h20);
    bus.FetchReady = 0; bus.Branch = 1; bus.BranchTarget = 32'h80;
    step(); bus.Branch = 0;
    chk("br_hold1", bus.FetchPC, 32'h20);
    step(); chk("br_hold2", bus.FetchPC, 32'h20);
    step(); chk("br_hold3", bus.FetchPC, 32'h20);
    chk("br_valid", 32'(bus.FetchValid), 32'd1);
    bus.FetchReady = 1;
    step();
    chk("br_pc",    bus.FetchPC, 32'h80);
    chk("br_redir", 32'(bus.Redirected), 32'd1);

    // All three requests at once.
    bus.JumpReg = 1; bus.RegTarget = 32'h300;
    bus.Jump = 1; bus.JumpAddress = 32'h200;
    bus.Branch = 1; bus.BranchTarget = 32'h100;
    step(); idle_inputs();
    chk("prio_pc", bus.FetchPC, 32'h300);

    // Stall with a jump in the first stalled cycle.
    goto_pc(32'h40);
    bus.Stall = 1; bus.Jump = 1; bus.JumpAddress = 32'h500;
    step(); bus.Jump = 0;
    chk("stall_hold1", bus.FetchPC, 32'h40);
    step();
    chk("stall_hold2", bus.FetchPC, 32'h40);
    bus.Stall = 0;
    step();
    chk("stall_pc",    bus.FetchPC, 32'h500);
    chk("stall_redir", 32'(bus.Redirected), 32'd1);

    // Wrap-around.
    goto_pc(32'hFFFF_FFFC);
    chk("wrap_plus4", bus.PCPlus4, 32'h0);
    step();
    chk("wrap_pc", bus.FetchPC, 32'h0);

`ifdef PC_MISALIGN_TRAP_EN
    bus.JumpReg = 1; bus.RegTarget = 32'h102;
    step(); bus.JumpReg = 0;
    chk("trap_mis",   32'(bus.Misaligned), 32'd1);
    chk("trap_valid", 32'(bus.FetchValid), 32'd0);
    chk("trap_pc",    bus.FetchPC, 32'h102);
    step(); step();
    chk("trap_sticky", 32'(bus.Misaligned), 32'd1);
    chk("trap_stuck",  32'(bus.FetchValid), 32'd0);
    do_reset();
    chk("trap_cleared", 32'(bus.Misaligned), 32'd0);
`else
    bus.JumpReg = 1; bus.RegTarget = 32'h103;
    step(); bus.JumpReg = 0;
    chk("align_pc",  bus.FetchPC, 32'h100);
    chk("align_mis", 32'(bus.Misaligned), 32'd0);
`endif

    // Mid-operation reset with a redirect parked.
    bus.FetchReady = 0; bus.Jump = 1; bus.JumpAddress = 32'h700;
    step(); idle_inputs();
    do_reset();
    bus.FetchReady = 1;
    step(); step();
    chk("rst_discard_pc", bus.FetchPC, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.Stall      = ($urandom_range(0, 4) == 0);
      bus.FetchReady = ($urandom_range(0, 3) != 0);
      bus.Jump       = ($urandom_range(0, 7) == 0);
      bus.Branch     = ($urandom_range(0, 5) == 0);
      bus.JumpReg    = ($urandom_range(0, 9) == 0);
      bus.JumpAddress  = rand_tgt();
      bus.BranchTarget = rand_tgt();
      bus.RegTarget    = rand_tgt();
      if ($urandom_range(0, 149) == 0) begin
        idle_inputs();
        do_reset();
      end else begin
        step();
      end
    end

    idle_inputs();
    step();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
